// File: rtl/digit_sprite_renderer.sv
// Address generator and pixel realignment stage for a 20x20 digit sprite ROM.
// Sprite position/enable are latched at frame start so a moving digit never tears.
module digit_sprite_renderer #(
    parameter int                SPR_W       = 20,
    parameter int                SPR_H       = 20,
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 8,
    parameter int                COORD_W     = 10,
    parameter logic [DATA_W-1:0] TRANSPARENT = 8'h00
) (
    input  logic               i_clk2,
    input  logic               i_rst,
    input  logic               i_pix_en,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    input  logic               i_enable,
    output logic [ADDR_W-1:0]  o_numberaddr,
    input  logic [DATA_W-1:0]  i_numberdata,
    output logic               o_hit,
    output logic [DATA_W-1:0]  o_pixel
);

    localparam logic signed [COORD_W:0] SPR_W_S = (COORD_W+1)'(SPR_W);
    localparam logic signed [COORD_W:0] SPR_H_S = (COORD_W+1)'(SPR_H);

    // Row-major sprite address; only called with 0 <= dx < SPR_W, 0 <= dy < SPR_H.
    function automatic logic [ADDR_W-1:0] sprite_addr(
        input logic signed [COORD_W:0] dx,
        input logic signed [COORD_W:0] dy
    );
        return ADDR_W'(dy * SPR_W_S + dx);
    endfunction

    logic [COORD_W-1:0] pos_x_sh;
    logic [COORD_W-1:0] pos_y_sh;
    logic               enable_sh;

    logic signed [COORD_W:0] dx_p0;
    logic signed [COORD_W:0] dy_p0;
    logic                    in_region_p0;
    logic [ADDR_W-1:0]       addr_p0;

    logic [ADDR_W-1:0]       addr_p1;
    logic                    vld_p1;

    logic                    opaque_p1;
    logic                    hit_p2;
    logic [DATA_W-1:0]       pixel_p2;

    // Shadow registers: loaded on frame start, independent of the pixel strobe.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            pos_x_sh  <= '0;
            pos_y_sh  <= '0;
            enable_sh <= 1'b0;
        end else if (i_frame_start) begin
            pos_x_sh  <= i_pos_x;
            pos_y_sh  <= i_pos_y;
            enable_sh <= i_enable;
        end
    end

    // Stage 0: region test on one extra sign bit so off-screen edges never wrap.
    always_comb begin
        dx_p0        = $signed({1'b0, i_x}) - $signed({1'b0, pos_x_sh});
        dy_p0        = $signed({1'b0, i_y}) - $signed({1'b0, pos_y_sh});
        in_region_p0 = enable_sh
                    && !dx_p0[COORD_W] && (dx_p0 < SPR_W_S)
                    && !dy_p0[COORD_W] && (dy_p0 < SPR_H_S);
        addr_p0      = in_region_p0 ? sprite_addr(dx_p0, dy_p0) : '0;
    end

    // Stage 1: ROM address register.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            addr_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (i_pix_en) begin
            addr_p1 <= addr_p0;
            vld_p1  <= in_region_p0;
        end
    end

    assign o_numberaddr = addr_p1;
    assign opaque_p1    = vld_p1 && (i_numberdata != TRANSPARENT);

    // Stage 2: ROM data realigned with the valid flag.
    always_ff @(posedge i_clk2 or posedge i_rst) begin
        if (i_rst) begin
            hit_p2   <= 1'b0;
            pixel_p2 <= '0;
        end else if (i_pix_en) begin
            hit_p2   <= opaque_p1;
            pixel_p2 <= opaque_p1 ? i_numberdata : '0;
        end
    end

    assign o_hit   = hit_p2;
    assign o_pixel = pixel_p2;

endmodule

// File: tb/tb_digit_sprite_renderer.sv
// Directed scoreboard bench for digit_sprite_renderer with a behavioural 1-clock ROM.
module tb_digit_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] x, y;
    logic       frame_start;
    logic [9:0] pos_x, pos_y;
    logic       enable;
    logic [9:0] addr;
    logic [7:0] data;
    logic       hit;
    logic [7:0] pixel;

    logic [7:0] rom [0:399];

    typedef struct packed {
        logic       hit;
        logic [7:0] pix;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_px, m_py;
    bit   m_en;
    logic [9:0] last_addr;
    exp_t       last_out;

    digit_sprite_renderer dut (
        .i_clk2        (clk),
        .i_rst         (rst),
        .i_pix_en      (pix_en),
        .i_x           (x),
        .i_y           (y),
        .i_frame_start (frame_start),
        .i_pos_x       (pos_x),
        .i_pos_y       (pos_y),
        .i_enable      (enable),
        .o_numberaddr  (addr),
        .i_numberdata  (data),
        .o_hit         (hit),
        .o_pixel       (pixel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data <= rom[addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [9:0] ea, input exp_t eo);
        chk({tag, ".addr"},  16'(addr),  16'(ea));
        chk({tag, ".hit"},   16'(hit),   16'(eo.hit));
        chk({tag, ".pixel"}, 16'(pixel), 16'(eo.pix));
    endtask

    task automatic model_reset();
        m_px = 0;
        m_py = 0;
        m_en = 1'b0;
        q.delete();
        q.push_back('0);
    endtask

    // One pixel strobe followed by one idle clock so ROM data settles.
    task automatic strobe(input int sx, input int sy, input string tag,
                          input bit fs = 1'b0, input int npx = 0, input int npy = 0,
                          input bit nen = 1'b0);
        bit   inr;
        int   ea;
        exp_t e;
        exp_t o;
        @(negedge clk);
        x = 10'(sx);
        y = 10'(sy);
        pix_en = 1'b1;
        frame_start = fs;
        if (fs) begin
            pos_x = 10'(npx);
            pos_y = 10'(npy);
            enable = nen;
        end
        inr = m_en && sx >= m_px && sx < m_px + 20 && sy >= m_py && sy < m_py + 20;
        ea = inr ? (sy - m_py) * 20 + (sx - m_px) : 0;
        e.hit = inr && (rom[ea] != 8'h00);
        e.pix = e.hit ? rom[ea] : 8'h00;
        q.push_back(e);
        if (fs) begin
            m_px = npx;
            m_py = npy;
            m_en = nen;
        end
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        frame_start = 1'b0;
        o = q.pop_front();
        chk_outputs(tag, 10'(ea), o);
        last_addr = 10'(ea);
        last_out = o;
        @(posedge clk);
    endtask

    task automatic frame(input int px, input int py, input bit en);
        @(negedge clk);
        frame_start = 1'b1;
        pos_x = 10'(px);
        pos_y = 10'(py);
        enable = en;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        m_px = px;
        m_py = py;
        m_en = en;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 400; i++) begin
            rom[i] = (i % 7 == 3) ? 8'h00 : 8'((i * 37 + 11) % 256);
            if (i % 7 != 3 && rom[i] == 8'h00) rom[i] = 8'h01;
        end
        rom[5] = 8'h00;
        rom[6] = 8'hE0;

        rst = 1'b1;
        pix_en = 1'b0;
        frame_start = 1'b0;
        x = '0;
        y = '0;
        pos_x = '0;
        pos_y = '0;
        enable = 1'b0;
        model_reset();
        #1;
        chk_outputs("reset", 10'd0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic corners
        frame(100, 50, 1'b1);
        strobe(100, 50, "tl");
        strobe(119, 69, "br");
        strobe(120, 50, "right_out");
        strobe(100, 70, "below_out");
        strobe(0, 0, "flush0");

        // One full row with margins on both sides
        for (int sx = 95; sx <= 125; sx++) strobe(sx, 55, $sformatf("row55_x%0d", sx));
        strobe(0, 0, "flush1");

        // Transparency
        strobe(105, 50, "transp5");
        strobe(106, 50, "opaque6");
        strobe(0, 0, "flush2");

        // Request changes without frame start must not take effect
        pos_x = 10'd300;
        strobe(101, 50, "nofs_old");
        strobe(300, 50, "nofs_new");
        // Frame start coincident with the strobe: compare uses old position
        strobe(101, 50, "coinc_old", 1'b1, 300, 50, 1'b1);
        strobe(300, 50, "newpos0");
        strobe(100, 50, "oldpos_miss");
        strobe(301, 50, "newpos1");
        strobe(0, 0, "flush3");

        // Clipping at the screen corner
        frame(630, 470, 1'b1);
        strobe(639, 479, "clip_br");
        strobe(0, 0, "clip_00");
        strobe(5, 475, "clip_5_475");
        strobe(630, 470, "clip_tl");
        strobe(639, 479, "clip_br2");
        strobe(631, 470, "clip_1");

        // Stall: inputs wiggle but pix_en stays low
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            x = 10'(632 + k);
            y = 10'(471 + k);
            @(posedge clk);
            #1;
            chk_outputs($sformatf("stall%0d", k), last_addr, last_out);
        end

        // Async reset mid-row
        frame(100, 50, 1'b1);
        strobe(100, 55, "pre_rst0");
        strobe(101, 55, "pre_rst1");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("async_rst", 10'd0, '0);
        @(negedge clk);
        rst = 1'b0;
        strobe(101, 50, "post_rst0");
        strobe(102, 50, "post_rst1");
        frame(100, 50, 1'b1);
        strobe(101, 50, "reen0");
        strobe(0, 0, "reen1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
